// File: rtl/lsu_port_arbiter_if.sv
// Requester/response and LSU-side bundle for lsu_port_arbiter.
// slave = arbiter view, master = environment (requesters plus LSU) view.
interface lsu_port_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic [1:0]      req_valid_i;
  logic [1:0]      req_ready_o;
  logic [2*AW-1:0] req_addr_i;
  logic [2*DW-1:0] req_wdata_i;
  logic [1:0]      req_we_i;
  logic [5:0]      req_dtype_i;
  logic [1:0]      rsp_valid_o;
  logic [1:0]      rsp_err_o;
  logic [DW-1:0]   rsp_data_o;
  logic [AW-1:0]   lsu_addr_o;
  logic [DW-1:0]   lsu_wdata_o;
  logic            lsu_we_o;
  logic [2:0]      lsu_dtype_o;
  logic [DW-1:0]   lsu_rdata_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_dtype_i, lsu_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o,
    output lsu_addr_o, lsu_wdata_o, lsu_we_o, lsu_dtype_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, req_we_i, req_dtype_i, lsu_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_data_o,
    input  lsu_addr_o, lsu_wdata_o, lsu_we_o, lsu_dtype_o
  );
endinterface

// File: rtl/lsu_port_arbiter.sv
// Two-port arbiter in front of the single LSU port, with in-order response routing.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module lsu_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_SPACE = 4096,
  parameter int RD_LATENCY    = 2
) (
  input logic               clk,
  input logic               reset_n,
  lsu_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(ADDRESS_SPACE);
  localparam int DW = DATA_WIDTH;

  typedef enum logic [2:0] {
    DT_BYTE   = 3'd0,
    DT_HALF   = 3'd1,
    DT_WORD   = 3'd2,
    DT_BYTE_U = 3'd3,
    DT_HALF_U = 3'd4,
    DT_NOP    = 3'd7
  } dtype_e;

  typedef struct packed {
    logic valid;
    logic port;
    logic err;
    logic is_load;
  } track_t;

  logic grant_valid;
  logic grant_port;
  logic prefer_port;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n)         rr_ptr <= 1'b0;
    else if (grant_valid) rr_ptr <= ~grant_port;
  end

  assign prefer_port = rr_ptr;
`else
  assign prefer_port = 1'b0;
`endif

  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = 1'b0;
    if (reset_n) begin
      case (bus.req_valid_i)
        2'b01:   begin grant_valid = 1'b1; grant_port = 1'b0;        end
        2'b10:   begin grant_valid = 1'b1; grant_port = 1'b1;        end
        2'b11:   begin grant_valid = 1'b1; grant_port = prefer_port; end
        default: ;
      endcase
    end
  end

  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_we;
  logic [2:0]    sel_dtype;
  logic          sel_err;

  assign sel_addr  = grant_port ? bus.req_addr_i[AW+:AW]   : bus.req_addr_i[0+:AW];
  assign sel_wdata = grant_port ? bus.req_wdata_i[DW+:DW]  : bus.req_wdata_i[0+:DW];
  assign sel_we    = grant_port ? bus.req_we_i[1]          : bus.req_we_i[0];
  assign sel_dtype = grant_port ? bus.req_dtype_i[3+:3]    : bus.req_dtype_i[0+:3];

  always_comb begin
    sel_err = 1'b1;
    case (sel_dtype)
      DT_BYTE, DT_BYTE_U: sel_err = 1'b0;
      DT_HALF, DT_HALF_U: sel_err = sel_addr[0];
      DT_WORD:            sel_err = |sel_addr[1:0];
      default:            sel_err = 1'b1;
    endcase
  end

  // Rejected requests are still accepted but present a no-op to the LSU.
  assign bus.req_ready_o = grant_valid ? (2'b01 << grant_port) : 2'b00;
  assign bus.lsu_addr_o  = sel_addr;
  assign bus.lsu_wdata_o = sel_wdata;
  assign bus.lsu_we_o    = grant_valid & ~sel_err & sel_we;
  assign bus.lsu_dtype_o = (grant_valid && !sel_err) ? sel_dtype : DT_NOP;

  track_t stage_in;
  track_t tail;
  track_t pipe_q [RD_LATENCY];

  assign stage_in = '{valid:   grant_valid,
                      port:    grant_port,
                      err:     grant_valid & sel_err,
                      is_load: grant_valid & ~sel_we};

  // NOTE: unlike a data RAM, this tracking array must be reset, or stale entries would emit responses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe_q <= '{default: '0};
    end else begin
      pipe_q[0] <= stage_in;
      for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = pipe_q[RD_LATENCY-1];

  // Gating with reset_n keeps entries that are about to be dropped from pulsing during reset.
  assign bus.rsp_valid_o = (reset_n && tail.valid) ? (2'b01 << tail.port) : 2'b00;
  assign bus.rsp_err_o   = (reset_n && tail.valid && tail.err) ? (2'b01 << tail.port) : 2'b00;
  assign bus.rsp_data_o  = (reset_n && tail.valid && tail.is_load && !tail.err) ? bus.lsu_rdata_i : '0;
endmodule
